multiport_regfile: RTL

Parametrised register file for the datapath, the next generation of the 32x32 two-read/one-write file. Provides width, depth and read-port count as parameters, and adds:
- two write ports with fixed priority
- an optional hardwired zero register
- a hardware clear sequencer that zeroes every entry after reset or on request, with Busy_o flagging the sweep

All writes occur on the rising edge of clk_i.

---
 rtl/multiport_regfile_if.sv | 26 ++
 rtl/multiport_regfile.sv | 113 +++++++++++
 2 files changed

// File: rtl/multiport_regfile_if.sv
// Bus bundle for multiport_regfile: read ports, two write ports, clear
// request and busy flag. The master drives addresses/writes, the register
// file (slave) drives read data and busy.
interface multiport_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] RdAddr_i;
    logic [NUM_RD*DATA_W-1:0] RdData_o;
    logic [1:0]               WrEn_i;
    logic [2*ADDR_W-1:0]      WrAddr_i;
    logic [2*DATA_W-1:0]      WrData_i;
    logic                     ClrReq_i;
    logic                     Busy_o;

    modport master (
        output RdAddr_i, WrEn_i, WrAddr_i, WrData_i, ClrReq_i,
        input  RdData_o, Busy_o
    );

    modport slave (
        input  RdAddr_i, WrEn_i, WrAddr_i, WrData_i, ClrReq_i,
        output RdData_o, Busy_o
    );
endinterface

// File: rtl/multiport_regfile.sv
// Parametrised multi-read, dual-write register file with optional hardwired
// zero entry and a hardware clear sweep (after reset or on ClrReq_i).
// Optional feature macro: REGFILE_BYPASS_EN enables write-to-read forwarding.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal operation: writes accepted, reads return array contents
// CLEAR | sweep: entry clr_cnt zeroed each cycle, reads return 0
module multiport_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multiport_regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_block;
    logic              wr_accept;
    logic [1:0]        wr_live;
    logic [NUM_RD*DATA_W-1:0] rd_data;

    // Reads are masked while reset is asserted or the sweep is running.
    assign rd_block  = rst_i || (state == CLEAR);
    // Writes only land in IDLE and are dropped in the cycle a clear is accepted.
    assign wr_accept = !rst_i && (state == IDLE) && !bus.ClrReq_i;

    // Per-port write qualification, discarding writes to the zero entry.
    always_comb begin
        wr_live = '0;
        for (int w = 0; w < 2; w++) begin
            wr_live[w] = bus.WrEn_i[w] &&
                         !((ZERO_REG != 0) && (bus.WrAddr_i[w*ADDR_W +: ADDR_W] == '0));
        end
    end

    // Sequencer: reset parks in CLEAR at entry 0; one sweep of DEPTH cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ClrReq_i) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // Array update: zero during reset/sweep, otherwise port 1 applied after port 0 so it wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem[0] <= '0;
        end else if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_accept) begin
            for (int w = 0; w < 2; w++) begin
                if (wr_live[w]) begin
                    mem[bus.WrAddr_i[w*ADDR_W +: ADDR_W]] <= bus.WrData_i[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Combinational read ports, with optional same-cycle forwarding from the write ports.
    always_comb begin
        rd_data = '0;
        if (!rd_block) begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (!((ZERO_REG != 0) && (bus.RdAddr_i[k*ADDR_W +: ADDR_W] == '0))) begin
                    rd_data[k*DATA_W +: DATA_W] = mem[bus.RdAddr_i[k*ADDR_W +: ADDR_W]];
                end
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < 2; w++) begin
                    if (wr_accept && wr_live[w] &&
                        (bus.WrAddr_i[w*ADDR_W +: ADDR_W] == bus.RdAddr_i[k*ADDR_W +: ADDR_W])) begin
                        rd_data[k*DATA_W +: DATA_W] = bus.WrData_i[w*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

    assign bus.RdData_o = rd_data;
    assign bus.Busy_o   = (state == CLEAR);
endmodule
